// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between two requesters; optional ALU_ARB_STATS_EN adds grant counters
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t            state_q, state_d;
  logic              last_q, owner_q, rsp0_valid_q, rsp1_valid_q, zero_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic [OP_W-1:0]   op_q;
  logic              g0, g1, rsp_hs;
  always_comb begin
    g0 = state_q == IDLE && req0_valid && (!req1_valid || last_q);
    g1 = state_q == IDLE && req1_valid && (!req0_valid || !last_q);
    rsp_hs = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);
    state_d = state_q == IDLE ? ((g0 || g1) ? EXEC : IDLE) :
              state_q == EXEC ? RESP :
              (rsp_hs ? IDLE : RESP);
  end
  // ready is masked by reset so no handshake can be seen while reset_n is low
  assign req0_ready  = reset_n && g0;
  assign req1_ready  = reset_n && g1;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (g0 && !(&cnt0_q)) cnt0_q <= cnt0_q + 1'b1;
      if (g1 && !(&cnt1_q)) cnt1_q <= cnt1_q + 1'b1;
    end
  end
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (g0 || g1) begin
        a_q     <= g1 ? req1_a : req0_a;
        b_q     <= g1 ? req1_b : req0_b;
        op_q    <= g1 ? req1_op : req0_op;
        owner_q <= g1;
        last_q  <= g1;
      end
      if (state_q == EXEC) begin
        result_q     <= alu_result;
        zero_q       <= alu_zero;
        rsp0_valid_q <= !owner_q;
        rsp1_valid_q <= owner_q;
      end
      if (state_q == RESP && rsp_hs) begin
        rsp0_valid_q <= 1'b0;
        rsp1_valid_q <= 1'b0;
      end
    end
  end
endmodule
